addsub_serial_nbit: RTL and testbench
=====================================

ADDSUB_SERIAL_NBIT -- requirements
Module: addsub_serial_nbit

Interface
REQ-001 Parameter N, default 16: operand and result width in bits.
REQ-002 Parameter K, default 4: bits processed per clock (chunk width); N SHALL be an integer multiple of K, K >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 x  input  N  operand A, captured when start is accepted.
REQ-007 y  input  N  operand B, captured when start is accepted.
REQ-008 add_n  input  1  mode, captured with operands: 0 = x+y, 1 = x-y.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 sum  output  N  result; held stable until the next accepted start.
REQ-012 cout  output  1  carry out of bit N-1 (subtract: 1 = no borrow).
REQ-013 ovf  output  1  two's-complement overflow.
REQ-014 zero  output  1  high when sum == 0.

Function
REQ-015 States: IDLE, RUN, DONE; C = N/K chunk cycles.
REQ-016 IDLE/DONE with start=1: capture x, y, add_n; carry register <= add_n; chunk index <= 0; go to RUN.
REQ-017 IDLE with start=0 stays IDLE; DONE with start=0 goes to IDLE.
REQ-018 RUN: each cycle adds chunk i of x, chunk i of (y XOR {N{add_n}}) and carry register, LSB chunk first; writes the K-bit result into chunk i of sum; updates carry register; increments index.
REQ-019 RUN on chunk index C-1: go to DONE; cout <= final carry; ovf <= (x[N-1] == y'[N-1]) && (sum[N-1] != x[N-1]), with y' the inverted-or-not operand; zero computed from the complete sum.
REQ-020 Latency: start accepted at edge 0 -> busy high cycles 1..C -> done high in cycle C+1 only.
REQ-021 start while RUN SHALL be ignored; the operation in flight is not disturbed.
REQ-022 start in the DONE cycle SHALL be accepted (back-to-back operation; throughput one result per C+1 cycles).
REQ-023 x, y, add_n changing after capture SHALL NOT affect the result.
REQ-024 sum, cout, ovf, zero SHALL keep the previous result through IDLE and update only during RUN/DONE of the next operation; they are valid as a set only when done=1 or in IDLE after done.
REQ-025 K = N SHALL give C = 1 (single-cycle add, done in cycle 2); K = 1 SHALL give bit-serial operation.
REQ-026 Result SHALL equal (x + (y XOR {N{add_n}}) + add_n) mod 2^N, with carry out as cout.

Reset
REQ-027 rst=1 at a rising edge: state <= IDLE; busy, done, cout, ovf <= 0; sum <= 0; zero <= 1; carry register and chunk index <= 0.
REQ-028 rst asserted during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-029 rst has priority over start in the same cycle.

Verification (N=8, K=2, C=4)
REQ-030 add_n=0, x=8'h5A, y=8'h33, start one cycle -> busy cycles 1-4, done cycle 5, sum=8'h8D, cout=0, ovf=1, zero=0.
REQ-031 add_n=1, x=8'h10, y=8'h01 -> sum=8'h0F, cout=1, ovf=0; x=8'h00, y=8'h01 -> sum=8'hFF, cout=0, ovf=0.
REQ-032 add_n=1, x=8'h80, y=8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-033 add_n=0, x=8'hFF, y=8'h01 -> sum=8'h00, cout=1, ovf=0, zero=1.
REQ-034 start re-pulsed with new operands during RUN -> ignored, first result unchanged; start in DONE cycle -> second done exactly 5 cycles later.
REQ-035 rst asserted in cycle 2 of RUN -> cycle after: busy=0, sum=0, zero=1, no done; repeat REQ-030 afterwards -> correct result.

Source files
------------

// File: rtl/addsub_serial_nbit.sv
// Chunk-serial N-bit adder/subtractor: K bits per clock, LSB chunk first,
// with registered carry-out, two's-complement overflow and zero flags.
module addsub_serial_nbit #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         add_n,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic [1:0]   dbg_state_o
);

    // Handshake: start is taken only in IDLE or DONE (ignored in RUN);
    // done is a one-cycle strobe and the result set stays put until the
    // next accepted start begins overwriting it.
    localparam int C  = N / K;
    localparam int IW = (C > 1) ? $clog2(C) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(C - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  xa_q;
    logic [N-1:0]  yb_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  sum_q;
    logic          busy_q;
    logic          done_q;
    logic          cout_q;
    logic          ovf_q;
    logic          zero_q;

    logic [31:0]   base;
    logic [K:0]    chunk_res;
    logic [N-1:0]  sum_d;
    logic          ovf_d;

    // yb_q already holds the inverted operand for subtraction, so the
    // chunk adder never needs to know the mode.
    always_comb begin
        base      = 32'(idx_q) * 32'(K);
        chunk_res = {1'b0, xa_q[base +: K]} + {1'b0, yb_q[base +: K]}
                  + {{K{1'b0}}, carry_q};
        sum_d     = sum_q;
        sum_d[base +: K] = chunk_res[K-1:0];
        ovf_d     = (xa_q[N-1] == yb_q[N-1]) && (sum_d[N-1] != xa_q[N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xa_q    <= '0;
            yb_q    <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        xa_q    <= x;
                        yb_q    <= y ^ {N{add_n}};
                        carry_q <= add_n;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_res[K];
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= chunk_res[K];
                        ovf_q   <= ovf_d;
                        zero_q  <= (sum_d == '0);
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Directed bench for addsub_serial_nbit at N=8, K=2 (four chunk cycles).
module tb_addsub_serial_nbit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       add_n;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic [1:0] dbg_state;

    int errors;
    int checks;

    addsub_serial_nbit #(.N(8), .K(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x           (x),
        .y           (y),
        .add_n       (add_n),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .zero        (zero),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an operation for one cycle, then scramble the inputs so a
    // design that keeps reading them live gives a wrong answer.
    task automatic launch(input logic [7:0] xv, input logic [7:0] yv, input logic m);
        start = 1'b1;
        x     = xv;
        y     = yv;
        add_n = m;
        @(negedge clk);
        start = 1'b0;
        x     = 8'($urandom_range(0, 255));
        y     = 8'($urandom_range(0, 255));
        add_n = 1'($urandom_range(0, 1));
    endtask

    // Entered in cycle 1 of an operation: busy for 4 cycles, done in cycle 5,
    // then the result must hold through IDLE.
    task automatic finish_check(input string tag, input logic [7:0] es,
                                input logic ec, input logic eo, input logic ez);
        for (int i = 0; i < 4; i++) begin
            chk1({tag, "_busy"}, busy, 1'b1);
            chk1({tag, "_nodone"}, done, 1'b0);
            @(negedge clk);
        end
        chk1({tag, "_done"}, done, 1'b1);
        chk1({tag, "_busy_lo"}, busy, 1'b0);
        chk2({tag, "_state"}, dbg_state, 2'd2);
        chk8({tag, "_sum"}, sum, es);
        chk1({tag, "_cout"}, cout, ec);
        chk1({tag, "_ovf"}, ovf, eo);
        chk1({tag, "_zero"}, zero, ez);
        @(negedge clk);
        chk1({tag, "_pulse"}, done, 1'b0);
        @(negedge clk);
        chk8({tag, "_hold"}, sum, es);
        chk1({tag, "_hold_cout"}, cout, ec);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        x      = 8'h00;
        y      = 8'h00;
        add_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk8("rst_sum", sum, 8'h00);
        chk1("rst_zero", zero, 1'b1);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk2("rst_state", dbg_state, 2'd0);

        launch(8'h5A, 8'h33, 1'b0);
        chk2("add_state_run", dbg_state, 2'd1);
        finish_check("add_5a_33", 8'h8D, 1'b0, 1'b1, 1'b0);

        launch(8'h10, 8'h01, 1'b1);
        finish_check("sub_10_01", 8'h0F, 1'b1, 1'b0, 1'b0);

        launch(8'h00, 8'h01, 1'b1);
        finish_check("sub_00_01", 8'hFF, 1'b0, 1'b0, 1'b0);

        launch(8'h80, 8'h01, 1'b1);
        finish_check("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0);

        launch(8'hFF, 8'h01, 1'b0);
        finish_check("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1);

        // start re-pulsed in RUN is ignored; start in DONE runs back-to-back
        launch(8'h5A, 8'h33, 1'b0);
        chk1("ign_busy_c1", busy, 1'b1);
        @(negedge clk);
        start = 1'b1;
        x     = 8'h11;
        y     = 8'h22;
        add_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("ign_busy_c3", busy, 1'b1);
        @(negedge clk);
        chk1("ign_nodone_c4", done, 1'b0);
        @(negedge clk);
        chk1("ign_done_c5", done, 1'b1);
        chk8("ign_sum", sum, 8'h8D);
        chk1("ign_ovf", ovf, 1'b1);
        launch(8'h10, 8'h01, 1'b1);
        finish_check("b2b", 8'h0F, 1'b1, 1'b0, 1'b0);

        // reset in cycle 2 of RUN aborts with no done pulse
        launch(8'h5A, 8'h33, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk8("abort_sum", sum, 8'h00);
        chk1("abort_zero", zero, 1'b1);
        chk1("abort_done", done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("abort_nodone", done, 1'b0);
        end
        launch(8'h5A, 8'h33, 1'b0);
        finish_check("after_abort", 8'h8D, 1'b0, 1'b1, 1'b0);

        // reset wins over start in the same cycle
        rst   = 1'b1;
        start = 1'b1;
        x     = 8'h01;
        y     = 8'h01;
        add_n = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk1("rst_prio_busy", busy, 1'b0);
        chk2("rst_prio_state", dbg_state, 2'd0);
        chk8("rst_prio_sum", sum, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
